// File: rtl/modexp_ctrl.sv
// Square-and-multiply sequencer: scans the exponent MSB-first and issues one
// modular multiplication at a time to an external pipelined multiplier.
`timescale 1ns/1ps
module modexp_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] result,
  output logic             mul_req,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_res,
  input  logic             mul_done,
  output logic [2:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE, SKIP, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_sr_q, exp_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mul_req_q, mul_req_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;

  logic msb;
  logic cnt_last;

  assign msb      = exp_sr_q[WIDTH-1];
  // cnt_q==1 means the bit being consumed now is the last one
  assign cnt_last = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    exp_sr_d  = exp_sr_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    result_d  = result_q;
    mul_req_d = 1'b0;
    mul_a_d   = '0;
    mul_b_d   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d   = base;
          exp_sr_d = exponent;
          cnt_d    = CW'(WIDTH);
          if (exponent == '0) begin
            result_d = WIDTH'(1);
            state_d  = DONE;
          end else begin
            state_d  = SKIP;
          end
        end
      end
      SKIP: begin
        exp_sr_d = exp_sr_q << 1;
        cnt_d    = cnt_q - CW'(1);
        if (msb) begin
          result_d = base_q;
          state_d  = cnt_last ? DONE : SQ_ISSUE;
        end
      end
      SQ_ISSUE: begin
        mul_req_d = 1'b1;
        mul_a_d   = result_q;
        mul_b_d   = result_q;
        state_d   = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mul_done) begin
          result_d = mul_res;
          if (msb) begin
            state_d = MUL_ISSUE;
          end else begin
            exp_sr_d = exp_sr_q << 1;
            cnt_d    = cnt_q - CW'(1);
            state_d  = cnt_last ? DONE : SQ_ISSUE;
          end
        end
      end
      MUL_ISSUE: begin
        mul_req_d = 1'b1;
        mul_a_d   = result_q;
        mul_b_d   = base_q;
        state_d   = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done) begin
          result_d = mul_res;
          exp_sr_d = exp_sr_q << 1;
          cnt_d    = cnt_q - CW'(1);
          state_d  = cnt_last ? DONE : SQ_ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      exp_sr_q  <= '0;
      cnt_q     <= '0;
      base_q    <= '0;
      result_q  <= '0;
      mul_req_q <= 1'b0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      exp_sr_q  <= exp_sr_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      result_q  <= result_d;
      mul_req_q <= mul_req_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign finish    = (state_q == DONE);
  assign result    = result_q;
  assign mul_req   = mul_req_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Directed bench for modexp_ctrl: WIDTH=8 against a (a*b) mod 97 multiplier
// model with a two-cycle issue-to-done latency; results go through a scoreboard.
`timescale 1ns/1ps
module tb_modexp_ctrl;

  localparam int W    = 8;
  localparam int MODN = 97;
  localparam int LAT  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] exponent = '0;
  logic         busy, finish, mul_req, mul_done;
  logic [W-1:0] result, mul_a, mul_b, mul_res;
  logic [2:0]   state_dbg;

  logic         mdl_done = 1'b0;
  logic [W-1:0] mdl_res = '0;
  logic         stray_done = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [W-1:0]   exp_q[$];
  int             req_log[$];
  logic [2*W-1:0] op_log[$];
  logic [W-1:0]   rb, re;

  modexp_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exponent(exponent),
    .busy(busy), .finish(finish), .result(result),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_res(mul_res), .mul_done(mul_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Multiplier model: one register stage after the registered request.
  always @(posedge clk) begin
    mdl_done <= mul_req;
    mdl_res  <= W'((32'(mul_a) * 32'(mul_b)) % MODN);
  end
  assign mul_done = mdl_done | stray_done;
  assign mul_res  = mdl_res;

  function automatic int ref_pow(int b, int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % MODN;
    return r;
  endfunction

  function automatic int ref_k(int e);
    int k = 0;
    for (int i = 0; i < W; i++) if (e[i]) k = i;
    return k;
  endfunction

  function automatic int ref_nmul(int e);
    if (e == 0) return 0;
    return ref_k(e) + $countones(e) - 1;
  endfunction

  function automatic int ref_fin(int e);
    if (e == 0) return 1;
    return W - ref_k(e) + 1 + ref_nmul(e) * (LAT + 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle, which becomes cycle 0 of the run.
  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                        input int pulse_a, input int pulse_b, input int stray_cyc,
                        input bit keep_start);
    int exp_fin;
    int cyc;
    bit seen;
    exp_fin = ref_fin(int'(e));
    exp_q.push_back(W'(ref_pow(int'(b), int'(e))));
    req_log.delete();
    op_log.delete();
    start = 1'b1; base = b; exponent = e;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      chk({tag, "_busy"}, 32'(busy), 32'(cyc <= exp_fin));
      if (mul_req) begin
        req_log.push_back(cyc);
        op_log.push_back({mul_a, mul_b});
      end
      if (finish) begin
        seen = 1'b1;
        chk({tag, "_fin_cycle"}, 32'(cyc), 32'(exp_fin));
        chk({tag, "_result"}, 32'(result), 32'(exp_q.pop_front()));
      end
      if (cyc == pulse_a || cyc == pulse_b) begin
        start = 1'b1;
        base = W'($urandom_range(0, MODN - 1));
        exponent = W'($urandom_range(1, 255));
      end else begin
        start = keep_start; base = b; exponent = e;
      end
      stray_done = (cyc == stray_cyc);
    end
    chk({tag, "_finish_seen"}, 32'(seen), 32'd1);
    if (!seen) void'(exp_q.pop_front());
    chk({tag, "_nmul"}, 32'(req_log.size()), 32'(ref_nmul(int'(e))));
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_finish_after"}, 32'(finish), 32'd0);
    start = keep_start; base = b; exponent = e; stray_done = 1'b0;
    if (!keep_start) begin
      @(negedge clk);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic chk_nominal_reqs(input string tag);
    logic [2*W-1:0] exp_ops [3];
    exp_ops[0] = {8'd3, 8'd3};
    exp_ops[1] = {8'd9, 8'd9};
    exp_ops[2] = {8'd81, 8'd3};
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_req_cycle"}, (i < req_log.size()) ? 32'(req_log[i]) : 32'hffff_ffff,
          32'(8 + 3 * i));
      chk({tag, "_req_ops"}, (i < op_log.size()) ? 32'(op_log[i]) : 32'hffff_ffff,
          32'(exp_ops[i]));
    end
  endtask

  initial begin
    // Reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_finish", 32'(finish), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_mul_req", 32'(mul_req), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Reset in cycle 5 of a base=2, exponent=255 run (first product is 4)
    start = 1'b1; base = 8'd2; exponent = 8'd255;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    chk("rstmid_result_before", 32'(result), 32'd4);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_result", 32'(result), 32'd0);
    chk("rstmid_mul_req", 32'(mul_req), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rstmid_no_finish", 32'(finish), 32'd0);
      chk("rstmid_no_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end

    // Directed runs
    run_op("nominal", 8'd3, 8'd5, -1, -1, -1, 1'b0);
    chk_nominal_reqs("nominal");
    run_op("exp0", 8'd3, 8'd0, -1, -1, -1, 1'b0);
    run_op("exp1", 8'd3, 8'd1, -1, -1, -1, 1'b0);
    run_op("full", 8'd2, 8'd255, -1, -1, -1, 1'b0);

    // Start re-pulsed in SKIP and DONE, stray mul_done in SKIP, start held after finish
    run_op("stray", 8'd3, 8'd5, 3, 16, 4, 1'b1);
    chk_nominal_reqs("stray");
    run_op("restart", 8'd3, 8'd5, -1, -1, -1, 1'b0);
    chk_nominal_reqs("restart");

    for (int i = 0; i < 4; i++) begin
      rb = W'($urandom_range(0, MODN - 1));
      re = W'($urandom_range(0, 255));
      run_op("rand", rb, re, -1, -1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
